// File: rtl/seven_segment_pkg.sv
// Shared constants, FSM state type and hex-to-segment table for the
// seven-segment display driver.
package seven_segment_pkg;

  localparam int NUM_DIGITS = 8;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  // Active-low cathode pattern {g,f,e,d,c,b,a} for one hex nibble
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

endpackage

// File: rtl/hex_to_seven_segment.sv
// Combinational nibble to active-low seven-segment cathode decoder.
module hex_to_seven_segment
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = hex_to_seg(nibble);

endmodule

// File: rtl/seven_segment_display_driver.sv
// Eight-digit hex display driver: frame-synchronous value commit, leading-zero
// blanking, PWM anode dimming, registered active-low outputs.
module seven_segment_display_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int PWM_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_DIGITS-1:0] digit_select,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [31:0]           load_value,
  input  logic [NUM_DIGITS-1:0] load_dp,
  input  logic                  load_lz_blank,
  input  logic                  display_en,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] an_n
);
  import seven_segment_pkg::*;

  localparam int IDX_W = $clog2(NUM_DIGITS);

  state_t                  state, state_next;
  logic [31:0]             stg_value, shd_value, eff_value;
  logic [NUM_DIGITS-1:0]   stg_dp, shd_dp, eff_dp;
  logic                    stg_lz;
  logic [NUM_DIGITS-1:0]   lz_mask, lz_next, eff_mask;
  logic [NUM_DIGITS-1:0]   prev_sel;
  logic [PWM_BITS-1:0]     pwm_cnt;
  logic                    accept, frame_start, sel_idle, commit;
  logic                    sel_valid, blank, dp_on, pwm_on;
  logic [IDX_W-1:0]        digit_idx;
  logic [3:0]              nibble;
  logic [6:0]              dec_seg, seg_d;
  logic                    dp_d;
  logic [NUM_DIGITS-1:0]   an_d;

  assign accept      = load_valid && load_ready;
  assign frame_start = (digit_select == 8'h80) && (prev_sel != 8'h80);
  assign sel_idle    = (digit_select == '1);
  assign commit      = (state == PENDING) && (frame_start || sel_idle);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = PENDING;
      PENDING: if (commit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Blank digit i while every nibble from the top down to i is zero; digit 0 always shows
  always_comb begin
    logic zero_run;
    lz_next  = '0;
    zero_run = stg_lz;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (stg_value[4*i +: 4] == 4'h0);
      lz_next[i] = zero_run && (i != 0);
    end
  end

  // The commit cycle already renders from staging so a new frame never shows an old digit
  assign eff_value = commit ? stg_value : shd_value;
  assign eff_dp    = commit ? stg_dp    : shd_dp;
  assign eff_mask  = commit ? lz_next   : lz_mask;

  assign sel_valid = (digit_select != '0) &&
                     ((digit_select & (digit_select - 1'b1)) == '0);

  always_comb begin
    digit_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_select[i]) digit_idx = i[IDX_W-1:0];
    end
  end

  assign nibble = eff_value[{digit_idx, 2'b00} +: 4];

  hex_to_seven_segment u_dec (
    .nibble (nibble),
    .seg_n  (dec_seg)
  );

  assign blank  = eff_mask[digit_idx];
  assign dp_on  = eff_dp[digit_idx];
  assign pwm_on = display_en && (pwm_cnt <= brightness);

  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    an_d  = '1;
    if (sel_valid) begin
      seg_d = blank ? SEG_BLANK : dec_seg;
      dp_d  = ~dp_on;
      if ((!blank || dp_on) && pwm_on) an_d = ~digit_select;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      load_ready <= 1'b1;
      stg_value  <= '0;
      stg_dp     <= '0;
      stg_lz     <= 1'b0;
      shd_value  <= '0;
      shd_dp     <= '0;
      lz_mask    <= '0;
      prev_sel   <= '0;
      pwm_cnt    <= '0;
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
      an_n       <= '1;
    end else begin
      state      <= state_next;
      load_ready <= (state_next == IDLE);
      prev_sel   <= digit_select;
      pwm_cnt    <= pwm_cnt + 1'b1;
      if (accept) begin
        stg_value <= load_value;
        stg_dp    <= load_dp;
        stg_lz    <= load_lz_blank;
      end
      if (commit) begin
        shd_value <= stg_value;
        shd_dp    <= stg_dp;
        lz_mask   <= lz_next;
      end
      seg_n <= seg_d;
      dp_n  <= dp_d;
      an_n  <= an_d;
    end
  end

endmodule

// File: tb/tb_seven_segment_display_driver.sv
// Directed self-checking bench for seven_segment_display_driver.
module tb_seven_segment_display_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  digit_select;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_value;
  logic [7:0]  load_dp;
  logic        load_lz_blank;
  logic        display_en;
  logic [3:0]  brightness;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [7:0]  an_n;

  int checks = 0;
  int errors = 0;

  always #20 clk = ~clk;

  seven_segment_display_driver #(
    .NUM_DIGITS (8),
    .PWM_BITS   (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .digit_select  (digit_select),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_value    (load_value),
    .load_dp       (load_dp),
    .load_lz_blank (load_lz_blank),
    .display_en    (display_en),
    .brightness    (brightness),
    .seg_n         (seg_n),
    .dp_n          (dp_n),
    .an_n          (an_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [6:0] seg, input logic dp, input logic [7:0] an);
    chk({tag, ".seg"}, {25'd0, seg_n}, {25'd0, seg});
    chk({tag, ".dp"},  {31'd0, dp_n},  {31'd0, dp});
    chk({tag, ".an"},  {24'd0, an_n},  {24'd0, an});
  endtask

  task automatic load(input logic [31:0] v, input logic [7:0] dp, input logic lz);
    load_valid    = 1'b1;
    load_value    = v;
    load_dp       = dp;
    load_lz_blank = lz;
  endtask

  initial begin
    int on_cnt;
    reset_n = 1'b0; digit_select = 8'hFF; load_valid = 1'b0; load_value = '0;
    load_dp = '0; load_lz_blank = 1'b0; display_en = 1'b1; brightness = 4'hF;
    tick(); tick();
    chk_out("reset", 7'h7F, 1'b1, 8'hFF);
    chk("reset.ready", {31'd0, load_ready}, 32'd1);

    // Load while selector idle: commits on the following cycle
    reset_n = 1'b1;
    load(32'h0000_00A5, 8'h00, 1'b0);
    tick();
    chk("idle.ready_low", {31'd0, load_ready}, 32'd0);
    load_valid = 1'b0;
    tick();
    chk("idle.ready_high", {31'd0, load_ready}, 32'd1);
    digit_select = 8'h01; tick();
    chk_out("a5.d0", 7'h12, 1'b1, 8'hFE);
    digit_select = 8'h02; tick();
    chk_out("a5.d1", 7'h08, 1'b1, 8'hFD);

    // Frame-aligned commit
    digit_select = 8'hFF;
    load(32'h1234_5678, 8'h00, 1'b0);
    tick(); load_valid = 1'b0; tick();
    digit_select = 8'h80; tick();
    chk_out("old.d7", 7'h79, 1'b1, 8'h7F);
    digit_select = 8'h40; tick();
    chk("old.d6", {25'd0, seg_n}, {25'd0, 7'h24});
    digit_select = 8'h20; tick();
    digit_select = 8'h10; tick();
    digit_select = 8'h08;
    load(32'h8765_4321, 8'h00, 1'b0);
    tick();
    load_valid = 1'b0;
    chk("mid.d3", {25'd0, seg_n}, {25'd0, 7'h12});
    chk("mid.ready", {31'd0, load_ready}, 32'd0);
    digit_select = 8'h04; tick();
    chk("mid.d2", {25'd0, seg_n}, {25'd0, 7'h02});
    digit_select = 8'h02; tick();
    digit_select = 8'h01; tick();
    chk("mid.d0", {25'd0, seg_n}, {25'd0, 7'h00});
    chk("mid.ready_d0", {31'd0, load_ready}, 32'd0);
    digit_select = 8'h80; tick();
    chk_out("new.d7", 7'h00, 1'b1, 8'h7F);
    chk("new.ready", {31'd0, load_ready}, 32'd1);
    digit_select = 8'h40; tick();
    chk("new.d6", {25'd0, seg_n}, {25'd0, 7'h78});

    // Leading-zero blanking with a decimal point on a blanked digit
    digit_select = 8'hFF;
    load(32'h0000_0040, 8'h10, 1'b1);
    tick(); load_valid = 1'b0; tick();
    digit_select = 8'h80; tick(); chk_out("lz.d7", 7'h7F, 1'b1, 8'hFF);
    digit_select = 8'h40; tick(); chk_out("lz.d6", 7'h7F, 1'b1, 8'hFF);
    digit_select = 8'h20; tick(); chk_out("lz.d5", 7'h7F, 1'b1, 8'hFF);
    digit_select = 8'h10; tick(); chk_out("lz.d4", 7'h7F, 1'b0, 8'hEF);
    digit_select = 8'h08; tick(); chk_out("lz.d3", 7'h7F, 1'b1, 8'hFF);
    digit_select = 8'h02; tick(); chk_out("lz.d1", 7'h19, 1'b1, 8'hFD);
    digit_select = 8'h01; tick(); chk_out("lz.d0", 7'h40, 1'b1, 8'hFE);

    // PWM duty and display enable
    brightness = 4'h3;
    tick();
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (an_n != 8'hFF) on_cnt++;
    end
    chk("pwm.on_cycles", on_cnt, 32'd4);
    display_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pwm.disabled", {24'd0, an_n}, {24'd0, 8'hFF});
    end
    display_en = 1'b1; brightness = 4'hF;

    // Non-one-hot selection blanks everything
    tick();
    chk("pre_bad.an", {24'd0, an_n}, {24'd0, 8'hFE});
    digit_select = 8'h0C; tick();
    chk_out("bad.0c", 7'h7F, 1'b1, 8'hFF);
    digit_select = 8'h00; tick();
    chk_out("bad.00", 7'h7F, 1'b1, 8'hFF);

    // Reset while pending drops the staged value
    digit_select = 8'h01;
    load(32'h5555_5555, 8'hFF, 1'b0);
    tick();
    load_valid = 1'b0;
    chk("rst.pending", {31'd0, load_ready}, 32'd0);
    reset_n = 1'b0; tick();
    reset_n = 1'b1;
    chk("rst.ready", {31'd0, load_ready}, 32'd1);
    chk_out("rst.out", 7'h7F, 1'b1, 8'hFF);
    tick();
    chk_out("rst.d0", 7'h40, 1'b1, 8'hFE);
    digit_select = 8'h80; tick();
    chk_out("rst.d7", 7'h40, 1'b1, 8'h7F);
    digit_select = 8'h10; tick();
    chk_out("rst.d4", 7'h40, 1'b1, 8'hEF);
    digit_select = 8'hFF; tick(); tick();
    digit_select = 8'h01; tick();
    chk("rst.no_commit", {25'd0, seg_n}, {25'd0, 7'h40});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_display_driver.md
# seven_segment_display_driver

Downstream consumer of the one-hot digit scan produced by the seven-segment digit selector. Holds a 32-bit value for eight hex digits and takes new values through a valid/ready handshake. New values are committed only at frame boundaries, so no frame mixes old and new digits. Drives the active-low cathodes, decimal point and gated anodes of the board display, with leading-zero blanking and PWM brightness.

## Interface
- NUM_DIGITS, 8, digits scanned (fixed at 8; one-hot width of `digit_select`)
- PWM_BITS, 4, width of brightness PWM counter and `brightness`
- clk  input  1  system clock (25 MHz)
- reset_n  input  1  synchronous, active-low reset
- digit_select  input  8  one-hot scan from digit selector; bit 7 scanned first; 8'hFF while selector is in reset
- load_valid  input  1  new display data offered
- load_ready  output  1  block can accept new data
- load_value  input  32  hex value; digit i shows load_value[4i+3:4i]
- load_dp  input  8  decimal point per digit, 1 = lit
- load_lz_blank  input  1  enable leading-zero blanking for this value
- display_en  input  1  0 forces all anodes off
- brightness  input  PWM_BITS  duty = (brightness+1)/2^PWM_BITS
- seg_n  output  7  cathodes {g,f,e,d,c,b,a}, active-low
- dp_n  output  1  decimal-point cathode, active-low
- an_n  output  8  anodes, active-low, gated

## Operation
- Handshake: transfer when load_valid && load_ready. Data goes into a staging register and the FSM moves IDLE -> PENDING. load_ready = (state == IDLE), registered.
- PENDING -> IDLE on commit, where staging is copied to shadow (value, dp, lz mask). Commit happens at either of:
  - a frame start: digit_select == 8'h80 and previous cycle's digit_select != 8'h80;
  - any cycle where digit_select == 8'hFF (selector idle).
- Back-to-back loads are impossible. load_ready is low for the whole of PENDING.
- Leading-zero mask is computed from staging at commit and registered with the shadow:
  - digit i is blanked iff load_lz_blank and nibbles 7..i are all zero;
  - digit 0 is never blanked.
- Per cycle, the active digit k is the index of the single set bit of digit_select.
  - Not one-hot (zero bits, several bits, or 8'hFF): seg_n = 7'h7F, dp_n = 1, an_n = 8'hFF.
  - Segment decode: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
  - Blanked digit: seg_n = 7'h7F. The anode is on only if its dp bit is set.
- PWM: free-running PWM_BITS counter. The anode is enabled iff pwm_cnt <= brightness and display_en. The cathodes are not gated.
- Reset values:
  - state IDLE, load_ready 1;
  - shadow and staging 0, lz mask 0;
  - pwm_cnt 0;
  - seg_n 7'h7F, dp_n 1, an_n 8'hFF.

## Timing
- All outputs are registered. Latency from digit_select / shadow / PWM to seg_n, dp_n, an_n is 1 cycle.
- Commit is visible on outputs 1 cycle after the commit cycle.
- load_ready falls the cycle after the accepting edge and rises the cycle after commit.
- If an accept and a commit condition fall in the same cycle, the commit does not use the newly accepted data. That data waits for the next boundary.
- reset_n low in PENDING drops the staged data. State returns to IDLE with reset values on the next edge.
- A digit_select change mid-frame has no effect on commit timing except through the 8'h80 rising detection.

## Structure
- Package `seven_segment_pkg`:
  - NUM_DIGITS localparam;
  - SEG_BLANK = 7'h7F;
  - hex-to-segment constant table / function;
  - FSM enum {IDLE, PENDING}.
- Sub-module `hex_to_seven_segment`: combinational nibble -> seg_n decoder, instantiated once on the muxed nibble.
- Top contains: FSM, staging/shadow regs, lz mask logic, one-hot-to-index plus validity check, PWM counter, output regs.

## Test plan
- Reset, then digit_select 8'hFF with load_value 32'h0000_00A5 offered: commits immediately. Scan 8'h01 gives seg_n 7'h12; scan 8'h02 gives seg_n 7'h08.
- Shadow 32'h1234_5678; load 32'h8765_4321 while digit_select = 8'h08. Remaining digits of the current frame still show the old value; the new value appears from the next 8'h80 (seg_n 7'h00). load_ready low until that commit.
- load_value 32'h0000_0040, lz_blank 1, dp 8'h10. an_n stays high for digits 7..5 and goes low for digit 4 (dp lit, seg 7'h7F), digit 1 shows 7'h19, digit 0 shows 7'h40.
- brightness 4'h3, display_en 1: an_n is active 4 of every 16 cycles. display_en 0: an_n = 8'hFF.
- digit_select = 8'h0C (two bits set): all outputs take blank values the next cycle.
- reset_n low one cycle while PENDING: load_ready 1 afterward and shadow 0; a later 8'h80 frame shows 7'h40 on all unblanked digits.
